control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Microcoded control unit for the 8-bit SAP datapath. Sits downstream of the instruction
//  register and consumes its upper nibble (opcode) plus ALU carry/zero flags. A microstep
//  counter and decode logic drive the 16-bit control word that sets load/enable on every
//  register, the ALU, the PC and the output stage.
// PARAMETERS
//  STEPS      5  microsteps per instruction window (T0..T4); legal 5..8; counter is 3 bits
//  EARLY_END  1  1: wrap to T0 after an opcode's last active step; 0: always run T0..STEPS-1
// PORTS
//  clk     in   1   system clock; step counter updates on FALLING edge
//  clr     in   1   reset, asynchronous, active-high
//  opcode  in   4   IR[7:4]; must be stable from the rising edge ending T1 through the last step
//  flag_c  in   1   ALU carry flag (registered elsewhere)
//  flag_z  in   1   ALU zero flag (registered elsewhere)
//  ctrl    out  16  control word, active-high; decoded combinationally from step/opcode/flags
//  step    out  3   current microstep (debug)
//  hlt     out  1   halted; equals ctrl[15]
// BEHAVIOUR
//  ctrl bit map: 15 HLT 14 MI 13 RI 12 RO 11 IO 10 II 9 AI 8 AO 7 EO 6 SU 5 BI 4 OI 3 CE 2 CO 1 J 0 FI
//  Reset (clr high, no clock needed): step=0, halted=0 -> ctrl=16'h4004 (CO|MI), hlt=0.
//  Step counter advances on negedge clk so ctrl settles half a cycle before the rising edge
//  on which registers capture; zero added latency beyond that half cycle.
//  Fetch, all opcodes: T0 CO|MI; T1 RO|II|CE.
//  0000 NOP  last=T1
//  0001 LDA  T2 IO|MI  T3 RO|AI                  last=T3
//  0010 ADD  T2 IO|MI  T3 RO|BI  T4 EO|AI|FI     last=T4
//  0011 SUB  T2 IO|MI  T3 RO|BI  T4 EO|AI|SU|FI  last=T4
//  0100 STA  T2 IO|MI  T3 AO|RI                  last=T3
//  0101 LDI  T2 IO|AI                            last=T2
//  0110 JMP  T2 IO|J                             last=T2
//  0111 JC   T2 IO|J if flag_c else 0            last=T2
//  1000 JZ   T2 IO|J if flag_z else 0            last=T2
//  1110 OUT  T2 AO|OI                            last=T2
//  1111 HLT  T2 HLT                              last=T2 (holds)
//  1001-1101 undefined: decode as NOP.
//  Conditional jumps: "last" step is fixed per opcode, independent of flag values.
//  Next step: EARLY_END=1 and step==last -> 0; step==STEPS-1 -> 0; else step+1.
//  Steps beyond an opcode's table (EARLY_END=0) output ctrl=0.
//  Halt: entering T2 with opcode 1111 sets halted; counter frozen at 2, hlt=1,
//  ctrl=16'h8000 until clr. Clock gating is external; opcode changes ignored while halted.
//  clr mid-instruction: abort immediately; step=0 and ctrl=16'h4004 while clr high; first
//  negedge after release advances to T1.
//  ctrl is never X after reset: unknown opcode/flags inputs resolve to NOP/not-taken.
// TESTING
//  1 clr pulse mid-T3 of LDA, no clock edge -> step=0, ctrl=16'h4004, hlt=0 immediately
//  2 opcode=0001 -> ctrl per negedge: 4004,1408,4800,1200, then 4004 (EARLY_END=1)
//  3 opcode=0010 then 0011 -> T4 ctrl=16'h0281 (ADD), 16'h02C1 (SUB); step returns to 0
//  4 opcode=0111 flag_c=0 -> T2 ctrl=16'h0000 then T0; flag_c=1 -> T2 ctrl=16'h0802
//  5 opcode=1111 -> T2 ctrl=16'h8000, hlt=1, step=2 for 10 clocks; clr -> step=0, hlt=0
//  6 EARLY_END=0, opcode=0000 -> steps 0..4, T2..T4 ctrl=0, wrap to 0 after T4

Source files
------------

// File: rtl/control_sequencer.sv
// Microcoded control unit for the 8-bit SAP datapath: microstep counter on the falling
// clock edge plus combinational decode of the 16-bit control word.
module control_sequencer #(
  parameter int STEPS     = 5,
  parameter bit EARLY_END = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  opcode,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        hlt
);

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  logic [2:0]  r_step;
  logic        r_halted;
  logic [2:0]  w_last;
  logic [2:0]  w_next;
  logic        w_enter_halt;
  logic [15:0] w_ctrl;

  // Last active microstep per opcode; undefined opcodes fall through to NOP.
  always_comb begin
    w_last = 3'd1;
    case (opcode)
      4'h1, 4'h4:                         w_last = 3'd3;
      4'h2, 4'h3:                         w_last = 3'd4;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: w_last = 3'd2;
      default:                            w_last = 3'd1;
    endcase
  end

  always_comb begin
    w_next = r_step + 3'd1;
    if (EARLY_END && (r_step == w_last)) begin
      w_next = 3'd0;
    end else if (r_step == LAST_STEP) begin
      w_next = 3'd0;
    end
  end

  assign w_enter_halt = !r_halted && (w_next == 3'd2) && (opcode == 4'hF);

  // Falling-edge update gives the decode half a cycle to settle before capture.
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      r_step   <= 3'd0;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      r_step <= w_next;
      if (w_enter_halt) begin
        r_halted <= 1'b1;
      end
    end
  end

  // Flags are tested with if so an unknown flag resolves to not-taken.
  always_comb begin
    w_ctrl = '0;
    if (r_halted) begin
      w_ctrl = C_HLT;
    end else begin
      case (r_step)
        3'd0: w_ctrl = C_CO | C_MI;
        3'd1: w_ctrl = C_RO | C_II | C_CE;
        3'd2: begin
          case (opcode)
            4'h1, 4'h2, 4'h3, 4'h4: w_ctrl = C_IO | C_MI;
            4'h5:                   w_ctrl = C_IO | C_AI;
            4'h6:                   w_ctrl = C_IO | C_J;
            4'h7: begin
              if (flag_c) begin
                w_ctrl = C_IO | C_J;
              end
            end
            4'h8: begin
              if (flag_z) begin
                w_ctrl = C_IO | C_J;
              end
            end
            4'hE:                   w_ctrl = C_AO | C_OI;
            4'hF:                   w_ctrl = C_HLT;
            default:                w_ctrl = '0;
          endcase
        end
        3'd3: begin
          case (opcode)
            4'h1:       w_ctrl = C_RO | C_AI;
            4'h2, 4'h3: w_ctrl = C_RO | C_BI;
            4'h4:       w_ctrl = C_AO | C_RI;
            default:    w_ctrl = '0;
          endcase
        end
        3'd4: begin
          case (opcode)
            4'h2:    w_ctrl = C_EO | C_AI | C_FI;
            4'h3:    w_ctrl = C_EO | C_AI | C_SU | C_FI;
            default: w_ctrl = '0;
          endcase
        end
        default: w_ctrl = '0;
      endcase
    end
  end

  assign ctrl = w_ctrl;
  assign step = r_step;
  assign hlt  = w_ctrl[15];

endmodule
